mem_bus_arbiter: RTL and testbench

//  Shares the single-port 256x16 RAM and the MMIO registers (LEDs, switches) between the
//  CPU and a second bus master (DMA/program loader). Round-robin arbitration, two-phase

---
 rtl/mem_bus_arbiter_pkg.sv | 18 +
 rtl/mem_bus_arbiter_mmio_decode.sv | 18 +
 rtl/mem_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the CPU/DMA memory bus: command codes, FSM states,
// bus owner and the MMIO map.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {MNONE = 2'b00, MREAD = 2'b01, MWRITE = 2'b10} cmd_e;
  typedef enum logic [1:0] {IDLE = 2'b00, ADDR = 2'b01, DATA = 2'b10} state_e;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_e;

  localparam int AW = 9;
  localparam logic [AW-1:0] MMIO_LED_ADDR = 9'h100;
  localparam logic [AW-1:0] MMIO_SW_ADDR  = 9'h140;

  // Only MREAD/MWRITE are real requests; 2'b11 counts as idle
  function automatic logic cmd_valid(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_mmio_decode.sv
// Address decode for the shared bus: RAM in the lower half, LED and switch
// registers at fixed addresses, everything else unmapped.
module mmio_decode import mem_bus_arbiter_pkg::*; #(
  parameter int            RAM_AW   = 8,
  parameter logic [AW-1:0] LED_ADDR = MMIO_LED_ADDR,
  parameter logic [AW-1:0] SW_ADDR  = MMIO_SW_ADDR
) (
  input  logic [AW-1:0] addr,
  output logic          sel_ram,
  output logic          sel_led,
  output logic          sel_sw
);

  assign sel_ram = ~addr[RAM_AW];
  assign sel_led = (addr == LED_ADDR);
  assign sel_sw  = (addr == SW_ADDR);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the single-port RAM and MMIO registers between
// the CPU and the DMA master. Each access is IDLE -> ADDR -> DATA.
module mem_bus_arbiter import mem_bus_arbiter_pkg::*; #(
  parameter int            DW       = 16,
  parameter int            RAM_AW   = 8,
  parameter logic [AW-1:0] LED_ADDR = MMIO_LED_ADDR,
  parameter logic [AW-1:0] SW_ADDR  = MMIO_SW_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cpu_cmd,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic [DW-1:0]     cpu_rdata,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [AW-1:0]     dma_addr,
  input  logic [DW-1:0]     dma_wdata,
  output logic [DW-1:0]     dma_rdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout,
  input  logic [7:0]        sw_in,
  output logic [7:0]        ledr_out
);

  typedef struct packed {
    owner_e        own;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_e        state_q, state_d;
  req_t          req_q;
  owner_e        last_q;
  logic          cpu_vld, dma_vld, pick_dma;
  logic          sel_ram, sel_led, sel_sw;
  logic [DW-1:0] rd_mux, cpu_rdata_q, dma_rdata_q;

  assign cpu_vld  = cmd_valid(cpu_cmd);
  assign dma_vld  = dma_req;
  // On contention the master that did not win last time goes next
  assign pick_dma = dma_vld & (~cpu_vld | (last_q == OWN_CPU));

  // Decode runs on the latched address so it is stable for ADDR and DATA
  mmio_decode #(.RAM_AW(RAM_AW), .LED_ADDR(LED_ADDR), .SW_ADDR(SW_ADDR)) u_dec (
    .addr    (req_q.addr),
    .sel_ram (sel_ram),
    .sel_led (sel_led),
    .sel_sw  (sel_sw)
  );

  // State register; async reset aborts any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake strobes, all decoded from state and req regs
  always_comb begin
    state_d   = state_q;
    ram_we    = 1'b0;
    cpu_ready = 1'b0;
    dma_gnt   = 1'b0;
    dma_done  = 1'b0;
    case (state_q)
      IDLE: if (cpu_vld | dma_vld) state_d = ADDR;
      ADDR: begin
        state_d = DATA;
        ram_we  = req_q.we & sel_ram;
        dma_gnt = (req_q.own == OWN_DMA);
      end
      DATA: begin
        state_d   = IDLE;
        dma_gnt   = (req_q.own == OWN_DMA);
        dma_done  = (req_q.own == OWN_DMA);
        cpu_ready = (req_q.own == OWN_CPU);
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner's request and remember who was granted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q  <= '0;
      last_q <= OWN_DMA;
    end else if (state_q == IDLE && (cpu_vld | dma_vld)) begin
      req_q.own   <= pick_dma ? OWN_DMA : OWN_CPU;
      req_q.we    <= pick_dma ? dma_we : (cpu_cmd == MWRITE);
      req_q.addr  <= pick_dma ? dma_addr : cpu_addr;
      req_q.wdata <= pick_dma ? dma_wdata : cpu_wdata;
      last_q      <= pick_dma ? OWN_DMA : OWN_CPU;
    end
  end

  // LED register, written on the edge that closes the ADDR phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      ledr_out <= 8'h00;
    else if (state_q == ADDR && req_q.we && sel_led) ledr_out <= req_q.wdata[7:0];
  end

  // Read data source for the DATA phase
  always_comb begin
    rd_mux = '0;
    if (sel_ram)      rd_mux = ram_dout;
    else if (sel_led) rd_mux = {{(DW-8){1'b0}}, ledr_out};
    else if (sel_sw)  rd_mux = {{(DW-8){1'b0}}, sw_in};
  end

  // Keep each master's last read data once its DATA phase ends
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else if (state_q == DATA) begin
      if (req_q.own == OWN_CPU) cpu_rdata_q <= rd_mux;
      else                      dma_rdata_q <= rd_mux;
    end
  end

  assign cpu_rdata = cpu_ready ? rd_mux : cpu_rdata_q;
  assign dma_rdata = dma_done  ? rd_mux : dma_rdata_q;
  assign ram_addr  = req_q.addr[RAM_AW-1:0];
  assign ram_din   = req_q.wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural 256x16 sync-read RAM.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clk = 1'b0, reset = 1'b0;
  logic [1:0]  cpu_cmd;
  logic [8:0]  cpu_addr, dma_addr;
  logic [15:0] cpu_wdata, cpu_rdata, dma_wdata, dma_rdata, ram_din, ram_dout;
  logic        cpu_ready, dma_req, dma_we, dma_gnt, dma_done, ram_we;
  logic [7:0]  ram_addr, sw_in, ledr_out;

  int n_chk = 0, n_err = 0, we_cnt = 0, overlap = 0;
  logic       logging = 1'b0;
  logic [7:0] log_q[$];
  logic [15:0] mem [0:255];

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_gnt(dma_gnt), .dma_done(dma_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .sw_in(sw_in), .ledr_out(ledr_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (ram_we) we_cnt++;
    if (logging) begin
      if (cpu_ready && dma_done) overlap++;
      if (cpu_ready)     log_q.push_back("C");
      else if (dma_done) log_q.push_back("D");
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cpu_acc(input logic [1:0] cmd, input logic [8:0] a, input logic [15:0] wd,
                         output logic [15:0] rd, output int lat);
    @(posedge clk); #1;
    cpu_cmd = cmd; cpu_addr = a; cpu_wdata = wd;
    lat = -1; rd = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cpu_ready) begin lat = i; rd = cpu_rdata; break; end
    end
    @(posedge clk); #1;
    cpu_cmd = MNONE;
  endtask

  task automatic dma_acc(input logic we, input logic [8:0] a, input logic [15:0] wd,
                         input logic drop, output logic [15:0] rd, output int lat,
                         output logic gnt);
    @(posedge clk); #1;
    dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = wd;
    lat = -1; rd = '0;
    @(posedge clk); #1;
    gnt = dma_gnt;
    if (drop) dma_req = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      if (dma_done) begin lat = i; rd = dma_rdata; break; end
    end
    @(posedge clk); #1;
    dma_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rd;
    int lat, w0;
    logic g;
    cpu_cmd = MNONE; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; sw_in = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cpu_ready), 0);
    chk("rst_gnt",   32'(dma_gnt),   0);
    chk("rst_done",  32'(dma_done),  0);
    chk("rst_we",    32'(ram_we),    0);
    chk("rst_led",   32'(ledr_out),  0);
    chk("rst_crd",   32'(cpu_rdata), 0);
    chk("rst_drd",   32'(dma_rdata), 0);
    reset = 1'b1;

    // RAM write then read back
    w0 = we_cnt;
    cpu_acc(MWRITE, 9'h042, 16'h0033, rd, lat);
    chk("t1_wlat", 32'(lat), 2);
    chk("t1_wecnt", 32'(we_cnt - w0), 1);
    chk("t1_mem", 32'(mem[8'h42]), 32'h33);
    w0 = we_cnt;
    cpu_acc(MREAD, 9'h042, 16'h0000, rd, lat);
    chk("t1_rlat", 32'(lat), 2);
    chk("t1_rd", 32'(rd), 32'h33);
    chk("t1_rwe", 32'(we_cnt - w0), 0);

    // LED register write and readback
    w0 = we_cnt;
    cpu_acc(MWRITE, 9'h100, 16'h0033, rd, lat);
    chk("t3_lat", 32'(lat), 2);
    chk("t3_led", 32'(ledr_out), 32'h33);
    chk("t3_we", 32'(we_cnt - w0), 0);
    chk("t3_mem0", 32'(mem[8'h00]), 0);
    cpu_acc(MREAD, 9'h100, 16'h0000, rd, lat);
    chk("t3_rd", 32'(rd), 32'h33);

    // Switch read, switch write ignored
    sw_in = 8'h35;
    cpu_acc(MREAD, 9'h140, 16'h0000, rd, lat);
    chk("t2_rd", 32'(rd), 32'h35);
    chk("t2_lat", 32'(lat), 2);
    w0 = we_cnt;
    cpu_acc(MWRITE, 9'h140, 16'h00AA, rd, lat);
    chk("t2_wlat", 32'(lat), 2);
    chk("t2_we", 32'(we_cnt - w0), 0);
    chk("t2_led", 32'(ledr_out), 32'h33);
    chk("t2_mem40", 32'(mem[8'h40]), 0);
    dma_acc(1'b0, 9'h042, 16'h0000, 1'b0, rd, lat, g);
    chk("t2_dgnt", 32'(g), 1);
    chk("t2_dlat", 32'(lat), 2);
    chk("t2_drd", 32'(rd), 32'h33);
    chk("t2_chold", 32'(cpu_rdata), 32'h35);

    // Contention from a fresh reset: C, D, C, D
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    chk("t4_ledrst", 32'(ledr_out), 0);
    @(posedge clk); #1;
    cpu_cmd = MREAD; cpu_addr = 9'h042;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 9'h140;
    logging = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    cpu_cmd = MNONE; dma_req = 1'b0; logging = 1'b0;
    repeat (4) @(posedge clk);
    chk("t4_cnt", 32'(log_q.size() >= 4), 1);
    chk("t4_g0", 32'(log_q[0]), 32'h43);
    chk("t4_g1", 32'(log_q[1]), 32'h44);
    chk("t4_g2", 32'(log_q[2]), 32'h43);
    chk("t4_g3", 32'(log_q[3]), 32'h44);
    chk("t4_ovl", 32'(overlap), 0);

    // Unmapped read; DMA drops request in ADDR
    cpu_acc(MREAD, 9'h1FF, 16'h0000, rd, lat);
    chk("t5_rd", 32'(rd), 0);
    chk("t5_lat", 32'(lat), 2);
    dma_acc(1'b0, 9'h140, 16'h0000, 1'b1, rd, lat, g);
    chk("t5_gnt", 32'(g), 1);
    chk("t5_dlat", 32'(lat), 2);
    chk("t5_drd", 32'(rd), 32'h35);

    // Reset during ADDR of a DMA RAM write
    cpu_acc(MWRITE, 9'h100, 16'h005A, rd, lat);
    chk("t6_led", 32'(ledr_out), 32'h5A);
    @(posedge clk); #1;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 9'h010; dma_wdata = 16'hBEEF;
    @(posedge clk); #1;
    chk("t6_gnt", 32'(dma_gnt), 1);
    chk("t6_we", 32'(ram_we), 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_werst", 32'(ram_we), 0);
    chk("t6_gntrst", 32'(dma_gnt), 0);
    chk("t6_ledrst", 32'(ledr_out), 0);
    dma_req = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_mem10", 32'(mem[8'h10]), 0);
    cpu_acc(MREAD, 9'h010, 16'h0000, rd, lat);
    chk("t6_rd", 32'(rd), 0);
    chk("t6_lat", 32'(lat), 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
